// File: rtl/evm_pkg.sv
// evm_pkg: shared state encoding, default sizing and switch-pattern helper for the EVM core.
package evm_pkg;
  localparam int MAX_PARTY = 16;
  localparam int DEF_N_PARTY = 3;
  localparam int DEF_CNT_W = 7;
  localparam int DEF_HOLD_CYC = 4;
  typedef enum logic [2:0] {IDLE, ARMED, HOLD, RELEASE, CLOSED} evm_state_t;
  function automatic logic is_onehot(input logic [MAX_PARTY-1:0] v);
    return (v != '0) && ((v & (v - MAX_PARTY'(1))) == '0);
  endfunction
endpackage

// File: rtl/evm_sat_counter.sv
// evm_sat_counter: per-party tally that holds at full scale and flags a vote cast against it.
module evm_sat_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat_hit
);
  assign sat_hit = inc && (cnt == '1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (inc && !sat_hit) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/evm_ballot_ctrl.sv
// evm_ballot_ctrl: armed one-vote-per-ballot EVM core with poll-close lock,
// saturating tallies, running total, sticky overflow and a timed accept indicator.
module evm_ballot_ctrl
  import evm_pkg::*;
#(
  parameter int N_PARTY = DEF_N_PARTY,
  parameter int CNT_W = DEF_CNT_W,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  localparam int TOT_W = CNT_W + $clog2(N_PARTY)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     voting_en,
  input  logic                     ballot_arm,
  input  logic                     close_poll,
  input  logic [N_PARTY-1:0]       voter_switch,
  output logic [N_PARTY*CNT_W-1:0] party_cnt,
  output logic [TOT_W-1:0]         total_cnt,
  output logic [N_PARTY-1:0]       vote_indicator,
  output logic                     invalid,
  output logic                     ready,
  output logic                     poll_closed,
  output logic                     overflow
);
  localparam int HW = $clog2(HOLD_CYC + 1);
  evm_state_t state;
  logic [N_PARTY-1:0] sw_q, sat_hit;
  logic [HW-1:0] hold_cnt;
  logic sw_one, sw_bad, count;
  assign sw_one = is_onehot(MAX_PARTY'(sw_q));
  assign sw_bad = (sw_q != '0) && !sw_one;
  // close_poll and a dropped enable both veto a vote on its count edge
  assign count = (state == ARMED) && voting_en && !close_poll && sw_one;
  for (genvar i = 0; i < N_PARTY; i++) begin : g_cnt
    evm_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .rst(rst),
      .inc(count && sw_q[i]),
      .cnt(party_cnt[i*CNT_W +: CNT_W]),
      .sat_hit(sat_hit[i])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sw_q <= '0;
      hold_cnt <= '0;
      total_cnt <= '0;
      vote_indicator <= '0;
      invalid <= 1'b0;
      ready <= 1'b0;
      poll_closed <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sw_q <= voter_switch;
      overflow <= overflow | (|sat_hit);
      if (count) total_cnt <= total_cnt + TOT_W'(1);
      if (close_poll) begin
        state <= CLOSED;
        poll_closed <= 1'b1;
        ready <= 1'b0;
        invalid <= 1'b0;
        vote_indicator <= '0;
      end else begin
        case (state)
          IDLE: if (ballot_arm && voting_en) begin
            state <= ARMED;
            ready <= 1'b1;
          end
          ARMED: if (!voting_en) begin
            state <= IDLE;
            ready <= 1'b0;
            invalid <= 1'b0;
          end else if (sw_one) begin
            state <= HOLD;
            ready <= 1'b0;
            invalid <= 1'b0;
            vote_indicator <= sw_q;
            hold_cnt <= '0;
          end else invalid <= sw_bad;
          HOLD: if (hold_cnt == HW'(HOLD_CYC - 1)) begin
            state <= RELEASE;
            vote_indicator <= '0;
          end else hold_cnt <= hold_cnt + HW'(1);
          // a switch still held from the accepted vote must be let go first
          RELEASE: if (sw_q == '0) state <= IDLE;
          CLOSED: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// tb_evm_ballot_ctrl: directed scoreboard bench for evm_ballot_ctrl (3 parties, 3-bit tallies).
module tb_evm_ballot_ctrl;
  localparam int NP = 3;
  localparam int CW = 3;
  localparam int HC = 4;
  localparam int TW = CW + $clog2(NP);
  logic clk = 1'b0;
  logic rst, voting_en, ballot_arm, close_poll;
  logic [NP-1:0] voter_switch, vote_indicator;
  logic [NP*CW-1:0] party_cnt;
  logic [TW-1:0] total_cnt;
  logic invalid, ready, poll_closed, overflow;
  typedef struct {
    logic [NP-1:0] ind;
    int party;
    logic [CW-1:0] tally;
    logic [TW-1:0] total;
    logic ovf;
  } exp_t;
  exp_t q[$];
  logic [CW-1:0] exp_tally [NP];
  logic [TW-1:0] exp_total;
  logic exp_ovf;
  int n_chk = 0;
  int n_bad = 0;
  int inv_cycles = 0;
  int inv_start;
  evm_ballot_ctrl #(.N_PARTY(NP), .CNT_W(CW), .HOLD_CYC(HC)) dut (
    .clk(clk),
    .rst(rst),
    .voting_en(voting_en),
    .ballot_arm(ballot_arm),
    .close_poll(close_poll),
    .voter_switch(voter_switch),
    .party_cnt(party_cnt),
    .total_cnt(total_cnt),
    .vote_indicator(vote_indicator),
    .invalid(invalid),
    .ready(ready),
    .poll_closed(poll_closed),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (invalid) inv_cycles++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic model_clear();
    for (int i = 0; i < NP; i++) exp_tally[i] = '0;
    exp_total = '0;
    exp_ovf = 1'b0;
  endtask
  task automatic arm();
    ballot_arm = 1'b1;
    step(1);
    ballot_arm = 1'b0;
    chk("arm_ready", 32'(ready), 32'd1);
  endtask
  task automatic push_vote(input int p);
    exp_t e;
    if (exp_tally[p] == '1) exp_ovf = 1'b1;
    else exp_tally[p] = exp_tally[p] + CW'(1);
    exp_total = exp_total + TW'(1);
    e.ind = NP'(1 << p);
    e.party = p;
    e.tally = exp_tally[p];
    e.total = exp_total;
    e.ovf = exp_ovf;
    q.push_back(e);
  endtask
  task automatic wait_vote(input int hold_exp);
    exp_t e;
    int seen = 0;
    int n = 0;
    e = q.pop_front();
    for (int i = 0; i < 10 && seen == 0; i++)
      if (vote_indicator != '0) seen = 1;
      else step(1);
    chk("vote_seen", 32'(seen), 32'd1);
    chk("vote_ind", 32'(vote_indicator), 32'(e.ind));
    chk("vote_tally", 32'(party_cnt[e.party*CW +: CW]), 32'(e.tally));
    chk("vote_total", 32'(total_cnt), 32'(e.total));
    chk("vote_ovf", 32'(overflow), 32'(e.ovf));
    chk("vote_ready", 32'(ready), 32'd0);
    chk("vote_invalid", 32'(invalid), 32'd0);
    while (vote_indicator != '0 && n < 20) begin
      n++;
      step(1);
    end
    chk("hold_len", 32'(n), 32'(hold_exp));
  endtask
  task automatic release_sw();
    voter_switch = '0;
    step(2);
  endtask
  initial begin
    rst = 1'b1;
    voting_en = 1'b0;
    ballot_arm = 1'b0;
    close_poll = 1'b0;
    voter_switch = '0;
    model_clear();
    step(2);
    chk("rst_party", 32'(party_cnt), 32'd0);
    chk("rst_total", 32'(total_cnt), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_ind", 32'(vote_indicator), 32'd0);
    chk("rst_closed", 32'(poll_closed), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    voting_en = 1'b1;
    step(1);
    // single clean vote for party 2
    arm();
    voter_switch = 3'b010;
    push_vote(1);
    wait_vote(HC);
    chk("t1_p1", 32'(party_cnt[0 +: CW]), 32'd0);
    chk("t1_p3", 32'(party_cnt[2*CW +: CW]), 32'd0);
    release_sw();
    // invalid pattern held 5 cycles, then corrected to party 3
    arm();
    inv_start = inv_cycles;
    voter_switch = 3'b011;
    step(5);
    chk("t2_inv_hi", 32'(invalid), 32'd1);
    chk("t2_no_count", 32'(total_cnt), 32'(exp_total));
    chk("t2_ready", 32'(ready), 32'd1);
    voter_switch = 3'b100;
    push_vote(2);
    wait_vote(HC);
    release_sw();
    chk("t2_inv_len", 32'(inv_cycles - inv_start), 32'd5);
    chk("t2_inv_lo", 32'(invalid), 32'd0);
    // held switch and re-arm attempt during HOLD
    arm();
    voter_switch = 3'b001;
    push_vote(0);
    step(2);
    ballot_arm = 1'b1;
    step(1);
    ballot_arm = 1'b0;
    wait_vote(HC - 1);
    step(14);
    chk("t3_total", 32'(total_cnt), 32'(exp_total));
    chk("t3_tally", 32'(party_cnt[0 +: CW]), 32'd1);
    chk("t3_ready", 32'(ready), 32'd0);
    release_sw();
    chk("t3_no_rearm", 32'(ready), 32'd0);
    // saturate party 1: eight more ballots, nine in all
    for (int i = 0; i < 8; i++) begin
      arm();
      voter_switch = 3'b001;
      push_vote(0);
      wait_vote(HC);
      release_sw();
    end
    chk("t4_sat", 32'(party_cnt[0 +: CW]), 32'd7);
    chk("t4_ovf", 32'(overflow), 32'd1);
    step(5);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    // cancel an armed ballot by dropping voting_en
    arm();
    voting_en = 1'b0;
    step(1);
    chk("t5_cancel_ready", 32'(ready), 32'd0);
    voting_en = 1'b1;
    voter_switch = 3'b001;
    step(3);
    chk("t5_cancel_total", 32'(total_cnt), 32'(exp_total));
    chk("t5_cancel_ind", 32'(vote_indicator), 32'd0);
    release_sw();
    // close_poll on the count edge drops the vote
    arm();
    voter_switch = 3'b100;
    step(1);
    close_poll = 1'b1;
    step(1);
    close_poll = 1'b0;
    chk("t5_closed", 32'(poll_closed), 32'd1);
    chk("t5_close_ready", 32'(ready), 32'd0);
    chk("t5_close_ind", 32'(vote_indicator), 32'd0);
    chk("t5_close_total", 32'(total_cnt), 32'(exp_total));
    chk("t5_close_p3", 32'(party_cnt[2*CW +: CW]), 32'(exp_tally[2]));
    voter_switch = '0;
    ballot_arm = 1'b1;
    step(1);
    ballot_arm = 1'b0;
    voter_switch = 3'b010;
    step(4);
    chk("t5_locked_ready", 32'(ready), 32'd0);
    chk("t5_locked_total", 32'(total_cnt), 32'(exp_total));
    chk("t5_locked_p2", 32'(party_cnt[CW +: CW]), 32'(exp_tally[1]));
    chk("t5_locked_closed", 32'(poll_closed), 32'd1);
    // async reset in the middle of HOLD
    voter_switch = '0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    model_clear();
    step(1);
    arm();
    voter_switch = 3'b010;
    step(2);
    chk("t6_in_hold", 32'(vote_indicator), 32'(3'b010));
    #2 rst = 1'b1;
    #1;
    chk("t6_ind", 32'(vote_indicator), 32'd0);
    chk("t6_total", 32'(total_cnt), 32'd0);
    chk("t6_party", 32'(party_cnt), 32'd0);
    chk("t6_ready", 32'(ready), 32'd0);
    chk("t6_closed", 32'(poll_closed), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    step(1);
    rst = 1'b0;
    release_sw();
    arm();
    voter_switch = 3'b100;
    push_vote(2);
    wait_vote(HC);
    release_sw();
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
